// File: rtl/uart_autobaud.sv
// Auto-baud controller: times the five falling edges of a 0x55 sync character and
// loads the rounded 16x-oversample divisor into the baud generator.
module uart_autobaud #(
  parameter int DVSR_W = 11,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              rx,
  output logic              busy,
  output logic [DVSR_W-1:0] dvsr,
  output logic              dvsr_we,
  output logic              done,
  output logic              err
);
  localparam int QW = CNT_W - 6;

  typedef enum logic [2:0] {IDLE, WAIT_HI, WAIT_FALL, MEASURE, CALC, FIN} state_t;

  state_t           state;
  logic             rx_m, rx_s, rx_d;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_lat;
  logic [2:0]       nfall;
  logic [QW-1:0]    q;
  logic             fifth_fall;

  // Rounded N/128; the extra top bit keeps N+64 from overflowing.
  function automatic logic [QW-1:0] rounded_q(input logic [CNT_W-1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, n} + (CNT_W+1)'(64);
    return s[CNT_W:7];
  endfunction

  function automatic logic q_in_range(input logic [QW-1:0] qv);
    return (32'(qv) >= 32'd2) && (32'(qv) <= (32'd1 << DVSR_W));
  endfunction

  function automatic logic [DVSR_W-1:0] q_to_dvsr(input logic [QW-1:0] qv);
    return DVSR_W'(32'(qv) - 32'd1);
  endfunction

  assign fall       = rx_d & ~rx_s;
  assign fifth_fall = fall && (nfall == 3'd4);
  assign q          = rounded_q(n_lat);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (state == MEASURE && fifth_fall)
      n_lat <= cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      dvsr    <= '0;
      dvsr_we <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      nfall   <= '0;
    end else begin
      dvsr_we <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= WAIT_HI;
              busy  <= 1'b1;
            end
          end
          WAIT_HI: begin
            if (rx_s)
              state <= WAIT_FALL;
          end
          WAIT_FALL: begin
            if (fall) begin
              cnt   <= CNT_W'(1);
              nfall <= 3'd1;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (!(&cnt))
              cnt <= cnt + CNT_W'(1);
            if (fall)
              nfall <= nfall + 3'd1;
            // A 5th fall in the saturation cycle still counts as a valid measurement.
            if (fifth_fall) begin
              state <= CALC;
            end else if (&cnt) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          CALC: begin
            busy <= 1'b0;
            if (q_in_range(q)) begin
              dvsr    <= q_to_dvsr(q);
              dvsr_we <= 1'b1;
              done    <= 1'b1;
              state   <= FIN;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
          FIN: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: drives 0x55 sync frames at several bit times and
// checks divisor, strobe timing, error paths, abort and reset behaviour.
module tb_uart_autobaud;
  localparam int DVSR_W = 6;
  localparam int CNT_W  = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              rx = 1'b1;
  logic              busy;
  logic [DVSR_W-1:0] dvsr;
  logic              dvsr_we;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int   done_cnt = 0, we_cnt = 0, err_cnt = 0, pair_bad = 0;
  int   done_cyc = 0, err_cyc = 0, busy_fall_cyc = 0;
  logic prev_busy = 1'b0;
  int   b_done, b_we, b_err, b_pair;
  int   fall5_cyc = 0;

  uart_autobaud #(.DVSR_W(DVSR_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .rx      (rx),
    .busy    (busy),
    .dvsr    (dvsr),
    .dvsr_we (dvsr_we),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (dvsr_we) we_cnt = we_cnt + 1;
    if (err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (done !== dvsr_we) pair_bad = pair_bad + 1;
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_busy = busy;
  end

  task automatic check_val(input string tag, input integer act, input integer exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic snap();
    b_done = done_cnt;
    b_we   = we_cnt;
    b_err  = err_cnt;
    b_pair = pair_bad;
  endtask

  // Sends the first nbits of a 0x55 frame (start, 8 data LSB first, stop).
  task automatic send_frame(input int bit_t, input int nbits, input int restart_at);
    logic [9:0] frame;
    int nf;
    frame = {1'b1, 8'h55, 1'b0};
    nf = 0;
    for (int i = 0; i < nbits; i++) begin
      if (rx && !frame[i]) begin
        nf++;
        if (nf == 5) fall5_cyc = cyc;
      end
      rx = frame[i];
      if (i == restart_at) begin
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(bit_t - 1);
      end else begin
        tick(bit_t);
      end
    end
  endtask

  task automatic good_run(input string tag, input int bit_t, input int exp_dvsr,
                          input int restart_at);
    snap();
    pulse_start();
    tick(2);
    send_frame(bit_t, 10, restart_at);
    tick(8);
    check_val({tag, "_done_cnt"}, done_cnt - b_done, 1);
    check_val({tag, "_we_cnt"}, we_cnt - b_we, 1);
    check_val({tag, "_err_cnt"}, err_cnt - b_err, 0);
    check_val({tag, "_we_eq_done"}, pair_bad - b_pair, 0);
    check_val({tag, "_latency"}, done_cyc - fall5_cyc, 4);
    check_val({tag, "_busy_drop"}, busy_fall_cyc, done_cyc);
    check_val({tag, "_dvsr"}, 32'(dvsr), exp_dvsr);
    check_val({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  task automatic err_run(input string tag, input int bit_t, input int exp_dvsr);
    snap();
    pulse_start();
    tick(2);
    send_frame(bit_t, 10, -1);
    tick(8);
    check_val({tag, "_err_cnt"}, err_cnt - b_err, 1);
    check_val({tag, "_done_cnt"}, done_cnt - b_done, 0);
    check_val({tag, "_we_cnt"}, we_cnt - b_we, 0);
    check_val({tag, "_err_latency"}, err_cyc - fall5_cyc, 4);
    check_val({tag, "_dvsr_hold"}, 32'(dvsr), exp_dvsr);
    check_val({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    int f1;
    bit seen;

    tick(3);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_dvsr", 32'(dvsr), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_dvsr_we", 32'(dvsr_we), 0);
    check_val("rst_err", 32'(err), 0);
    reset = 1'b0;
    tick(3);

    // N=6944 -> q=54 -> 53
    good_run("b868", 868, 53, -1);
    // N=160 -> q=1 -> out of range
    err_run("b20", 20, 53);
    // N=8192 -> q=64 = 2**DVSR_W, largest accepted
    good_run("b1024", 1024, 63, -1);
    // N=8320 -> q=65 > 2**DVSR_W
    err_run("b1040", 1040, 63);
    // N=240 -> q=2, smallest accepted; extra start mid-frame must be ignored
    good_run("b30_restart", 30, 1, 3);

    // Timeout: single fall then rx held low until the counter saturates.
    snap();
    pulse_start();
    tick(2);
    rx = 1'b0;
    f1 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (err_cnt != b_err) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("tmo_seen", 32'(seen), 1);
    check_val("tmo_latency", err_cyc - f1, (1 << CNT_W) + 2);
    check_val("tmo_done_cnt", done_cnt - b_done, 0);
    rx = 1'b1;
    tick(5);
    check_val("tmo_err_cnt", err_cnt - b_err, 1);
    check_val("tmo_busy", 32'(busy), 0);
    check_val("tmo_dvsr_hold", 32'(dvsr), 1);

    // Abort after the 3rd fall.
    snap();
    pulse_start();
    tick(2);
    send_frame(200, 5, -1);
    check_val("abt_busy_before", 32'(busy), 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    rx = 1'b1;
    tick(60);
    check_val("abt_busy", 32'(busy), 0);
    check_val("abt_done_cnt", done_cnt - b_done, 0);
    check_val("abt_we_cnt", we_cnt - b_we, 0);
    check_val("abt_err_cnt", err_cnt - b_err, 0);
    check_val("abt_dvsr_hold", 32'(dvsr), 1);
    good_run("rerun", 868, 53, -1);

    // Reset in MEASURE.
    snap();
    pulse_start();
    tick(2);
    send_frame(100, 4, -1);
    check_val("rm_busy_before", 32'(busy), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_val("rm_busy", 32'(busy), 0);
    check_val("rm_dvsr", 32'(dvsr), 0);
    check_val("rm_done", 32'(done), 0);
    check_val("rm_dvsr_we", 32'(dvsr_we), 0);
    check_val("rm_err", 32'(err), 0);
    rx = 1'b1;
    tick(1000);
    check_val("rm_done_cnt", done_cnt - b_done, 0);
    check_val("rm_err_cnt", err_cnt - b_err, 0);
    check_val("rm_busy_end", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
